// File: rtl/mips_pkg.sv
// Shared types for the fetch stage: IF/ID payload, FSM states and the NOP encoding.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and IF/ID outputs.
interface fetch_stage_if;

    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    modport master (
        input  stall, branch_taken, branch_target, imem_rdata, imem_valid,
        output imem_req, imem_addr, if_id_instr, if_id_pc4, if_id_valid
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_rdata, imem_valid,
        input  imem_req, imem_addr, if_id_instr, if_id_pc4, if_id_valid
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry hold register for an instruction word that returns while IF/ID is stalled.
// Latency: captured word readable the cycle after load.
// Backpressure: none; clear wins over load.
module fetch_skid
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        vld
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= NOP_INSTR;
            vld  <= 1'b0;
        end else if (clear) begin
            dout <= NOP_INSTR;
            vld  <= 1'b0;
        end else if (load) begin
            dout <= din;
            vld  <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register; optional FETCH_PERF_EN adds stall/flush counters.
// Latency: imem response at cycle N shows on IF/ID at N+1.
// Backpressure: stall freezes PC and IF/ID; branch_taken overrides stall and inserts a bubble.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  stall_cycles,
    output logic [31:0]  flush_count
`endif
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt, pc_inc;
    if_id_t       if_id, if_id_nxt;
    logic         skid_load, skid_clear, skid_vld;
    logic [31:0]  skid_dat;

    assign pc_inc = pc + STEP;

    fetch_skid u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .din   (bus.imem_rdata),
        .dout  (skid_dat),
        .vld   (skid_vld)
    );

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        if_id_nxt  = if_id;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (bus.branch_taken) begin
            pc_nxt     = bus.branch_target;
            if_id_nxt  = IF_ID_BUBBLE;
            skid_clear = 1'b1;
            // A request still in flight must have its response swallowed.
            if ((state == S_FETCH || state == S_DROP) && !bus.imem_valid)
                state_nxt = S_DROP;
            else
                state_nxt = S_FETCH;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (bus.imem_valid) begin
                        if (bus.stall) begin
                            skid_load = 1'b1;
                            state_nxt = S_HOLD;
                        end else begin
                            if_id_nxt = '{instr: bus.imem_rdata, pc4: pc_inc, valid: 1'b1};
                            pc_nxt    = pc_inc;
                        end
                    end else if (!bus.stall) begin
                        if_id_nxt = IF_ID_BUBBLE;
                    end
                end
                S_HOLD: begin
                    if (!bus.stall) begin
                        if_id_nxt  = '{instr: skid_dat, pc4: pc_inc, valid: skid_vld};
                        pc_nxt     = pc_inc;
                        skid_clear = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (bus.imem_valid)
                        state_nxt = S_FETCH;
                    if (!bus.stall)
                        if_id_nxt = IF_ID_BUBBLE;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            if_id <= IF_ID_BUBBLE;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if_id <= if_id_nxt;
        end
    end

    assign bus.imem_req    = rst_n && (state == S_FETCH);
    assign bus.imem_addr   = pc;
    assign bus.if_id_instr = if_id.instr;
    assign bus.if_id_pc4   = if_id.pc4;
    assign bus.if_id_valid = if_id.valid;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= 32'h0;
            flush_count  <= 32'h0;
        end else begin
            if (bus.stall && !bus.branch_taken && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'h1;
            if (bus.branch_taken && flush_count != 32'hFFFF_FFFF)
                flush_count <= flush_count + 32'h1;
        end
    end
`endif

endmodule
